// File: rtl/pnq_ctrl.sv
// pnq_ctrl: N-buffer packet controller moving buffer indices between snooper (A),
// CPU filter (B) and forwarder (C). Optional feature macro: PNQ_STARVE_CNT_EN.
module pnq_ctrl #(
  parameter int NUM_BUFS  = 4,
  parameter int SEL_WIDTH = 2,
  parameter int CNT_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  A_done,
  output logic                  A_done_ack,
  output logic                  rdy_for_A,
  input  logic                  rdy_for_A_ack,
  input  logic                  B_acc,
  input  logic                  B_rej,
  output logic                  B_done_ack,
  output logic                  rdy_for_B,
  input  logic                  rdy_for_B_ack,
  input  logic                  C_done,
  input  logic                  rdy_for_C_ack,
  output logic                  C_done_ack,
  output logic                  rdy_for_C,
  output logic [SEL_WIDTH-1:0]  sn_sel,
  output logic [SEL_WIDTH-1:0]  cpu_sel,
  output logic [SEL_WIDTH-1:0]  fwd_sel,
  output logic [2*NUM_BUFS-1:0] buf_owner,
  output logic [NUM_BUFS-1:0]   reset_len,
  output logic [CNT_WIDTH-1:0]  sn_starve_cnt
);
  localparam int PW = $clog2(NUM_BUFS);
  localparam int CW = $clog2(NUM_BUFS + 1);
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_RDY   = 2'd1;
  localparam logic [1:0] ST_BUSY  = 2'd2;

  // Agent j (0=A, 1=B, 2=C) pops from queue j (0=FREE, 1=FILT, 2=FWD).
  logic [SEL_WIDTH-1:0]  r_mem [3][NUM_BUFS];
  logic [PW-1:0]         r_rd  [3];
  logic [PW-1:0]         r_wr  [3];
  logic [CW-1:0]         r_cnt [3];
  logic [1:0]            r_st  [3];
  logic [SEL_WIDTH-1:0]  r_sel [3];
  logic [2:0]            r_rdy;
  logic [2:0]            r_ack;
  logic [2*NUM_BUFS-1:0] r_owner;

  logic [2:0]            w_pop;
  logic [2:0]            w_push;
  logic [2:0]            w_fin;
  logic [2:0]            w_rdy_ack;
  logic [SEL_WIDTH-1:0]  w_push_dat [3];
  logic [1:0]            w_st_nxt   [3];
  logic [SEL_WIDTH-1:0]  w_sel_nxt  [3];
  logic [2*NUM_BUFS-1:0] w_owner_nxt;
  logic                  w_a_fin;
  logic                  w_b_acc;
  logic                  w_b_rej;
  logic                  w_c_fin;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(NUM_BUFS - 1)) ? '0 : p + PW'(1);
  endfunction

  assign w_rdy_ack = {rdy_for_C_ack, rdy_for_B_ack, rdy_for_A_ack};
  assign w_a_fin   = (r_st[0] == ST_BUSY) && A_done;
  assign w_b_acc   = (r_st[1] == ST_BUSY) && B_acc;
  assign w_c_fin   = (r_st[2] == ST_BUSY) && C_done;
  // C owns the FREE write port on a collision; the reject stays BUSY and retries.
  assign w_b_rej   = (r_st[1] == ST_BUSY) && B_rej && !w_c_fin;
  assign w_fin     = {w_c_fin, w_b_acc | w_b_rej, w_a_fin};
  assign w_push    = {w_b_acc, w_a_fin, w_c_fin | w_b_rej};

  assign w_push_dat[0] = w_c_fin ? r_sel[2] : r_sel[1];
  assign w_push_dat[1] = r_sel[0];
  assign w_push_dat[2] = r_sel[1];

  always_comb begin
    w_pop = '0;
    for (int j = 0; j < 3; j++) begin
      w_pop[j]     = (r_st[j] == ST_EMPTY) && (r_cnt[j] != '0);
      w_st_nxt[j]  = r_st[j];
      w_sel_nxt[j] = r_sel[j];
      case (r_st[j])
        ST_EMPTY: if (w_pop[j]) begin
          w_st_nxt[j]  = ST_RDY;
          w_sel_nxt[j] = r_mem[j][r_rd[j]];
        end
        ST_RDY:   if (w_rdy_ack[j]) w_st_nxt[j] = ST_BUSY;
        ST_BUSY:  if (w_fin[j]) w_st_nxt[j] = ST_EMPTY;
        default:  w_st_nxt[j] = ST_EMPTY;
      endcase
    end
    w_owner_nxt = '0;
    for (int i = 0; i < NUM_BUFS; i++) begin
      for (int j = 0; j < 3; j++) begin
        if ((w_st_nxt[j] != ST_EMPTY) && (w_sel_nxt[j] == SEL_WIDTH'(i)))
          w_owner_nxt[2*i +: 2] = 2'(j + 1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int j = 0; j < 3; j++) begin
        r_st[j]  <= ST_EMPTY;
        r_sel[j] <= '0;
        r_rd[j]  <= '0;
        r_wr[j]  <= '0;
        r_cnt[j] <= (j == 0) ? CW'(NUM_BUFS) : '0;
      end
      for (int i = 0; i < NUM_BUFS; i++) r_mem[0][i] <= SEL_WIDTH'(i);
      r_rdy   <= '0;
      r_ack   <= '0;
      r_owner <= '0;
    end else begin
      for (int j = 0; j < 3; j++) begin
        r_st[j]  <= w_st_nxt[j];
        r_sel[j] <= w_sel_nxt[j];
        r_rdy[j] <= (w_st_nxt[j] == ST_RDY);
        r_ack[j] <= w_fin[j];
        if (w_push[j]) begin
          r_mem[j][r_wr[j]] <= w_push_dat[j];
          r_wr[j]           <= ptr_inc(r_wr[j]);
        end
        if (w_pop[j]) r_rd[j] <= ptr_inc(r_rd[j]);
        case ({w_push[j], w_pop[j]})
          2'b10:   r_cnt[j] <= r_cnt[j] + CW'(1);
          2'b01:   r_cnt[j] <= r_cnt[j] - CW'(1);
          default: r_cnt[j] <= r_cnt[j];
        endcase
      end
      r_owner <= w_owner_nxt;
    end
  end

  always_comb begin
    reset_len = '0;
    for (int i = 0; i < NUM_BUFS; i++)
      reset_len[i] = rdy_for_A & rdy_for_A_ack & (r_sel[0] == SEL_WIDTH'(i));
  end

`ifdef PNQ_STARVE_CNT_EN
  logic [CNT_WIDTH-1:0] r_starve;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_starve <= '0;
    else if ((r_st[0] == ST_EMPTY) && (r_cnt[0] == '0) && (r_starve != '1))
      r_starve <= r_starve + CNT_WIDTH'(1);
  end
  assign sn_starve_cnt = r_starve;
`else
  assign sn_starve_cnt = '0;
`endif

  assign rdy_for_A  = r_rdy[0];
  assign rdy_for_B  = r_rdy[1];
  assign rdy_for_C  = r_rdy[2];
  assign A_done_ack = r_ack[0];
  assign B_done_ack = r_ack[1];
  assign C_done_ack = r_ack[2];
  assign sn_sel     = r_sel[0];
  assign cpu_sel    = r_sel[1];
  assign fwd_sel    = r_sel[2];
  assign buf_owner  = r_owner;

endmodule

// File: doc/pnq_ctrl.md
# pnq_ctrl

- Parametrised N-buffer successor to the fixed three-buffer packet-buffer controller.
- Owns `NUM_BUFS` packet buffers and moves their indices between three agents:
  - snooper (A) writes packets;
  - CPU filter (B) accepts or rejects them;
  - forwarder (C) drains accepted packets.
- Produces per-agent buffer selects and per-buffer ownership codes for the existing mux and `p_ng` instances.
- Keeps packet order end-to-end and lets the snooper keep running while the filter or forwarder lags, up to `NUM_BUFS`.

## Interface

Parameters:
- `NUM_BUFS`, default 4: number of buffers; legal range 2..16.
- `SEL_WIDTH`, default 2: width of a buffer index; must be at least clog2(`NUM_BUFS`).
- `CNT_WIDTH`, default 32: width of the starvation counter.

Ports:
- `clk`  in  1  — sole clock.
- `rst`  in  1  — asynchronous, active-low reset.
- `A_done`  in  1  — snooper finished its buffer; held high until `A_done_ack`.
- `A_done_ack`  out  1  — one-cycle acknowledge of `A_done`.
- `rdy_for_A`  out  1  — buffer offered to snooper.
- `rdy_for_A_ack`  in  1  — snooper takes the offered buffer.
- `B_acc`, `B_rej`  in  1 each  — CPU verdict; held until `B_done_ack`; never both high.
- `B_done_ack`, `rdy_for_B`  out  1 each.
- `rdy_for_B_ack`  in  1.
- `C_done`, `rdy_for_C_ack`  in  1 each.
- `C_done_ack`, `rdy_for_C`  out  1 each.
- `sn_sel`, `cpu_sel`, `fwd_sel`  out  `SEL_WIDTH`  — buffer index held by each agent.
- `buf_owner`  out  2*`NUM_BUFS`  — owner code per buffer, bits [2i+1:2i]: 00 none, 01 snooper, 10 CPU, 11 forwarder.
- `reset_len`  out  `NUM_BUFS`  — clears the byte length of buffer i.
- `sn_starve_cnt`  out  `CNT_WIDTH`  — cycles the snooper was starved (see Configuration).

## Operation

Queues:
- Three circular index FIFOs, each `NUM_BUFS` deep:
  - FREE, which holds indices 0..`NUM_BUFS`-1 in ascending order after reset;
  - FILT, which starts empty;
  - FWD, which starts empty.
- Each index is in exactly one queue or held by exactly one agent, so no FIFO can overflow.

Agent state machine (one per agent):
- States are EMPTY, RDY and BUSY.
- Agent A uses source FREE and destination FILT.
- Agent B uses source FILT and destination FWD on accept, or FREE on reject.
- Agent C uses source FWD and destination FREE.
- EMPTY → RDY when the source queue is non-empty: pop the head into the agent's sel register and assert rdy.
- RDY → BUSY when the rdy_ack input is 1: deassert rdy.
- BUSY → EMPTY when the done input is 1 and the push is granted: push sel to the destination, pulse done_ack for one cycle.
- A done input seen while the agent is not in BUSY is ignored.

Ownership and length reset:
- `buf_owner` is 00 for queued indices. For a held index it is the holder's code, in both RDY and BUSY.
- `reset_len[i]` = `rdy_for_A` & `rdy_for_A_ack` & (`sn_sel`==i). It is combinational.

Push conflicts and ordering:
- Each queue accepts one push per cycle.
- FREE can be targeted by a B reject and a C done in the same cycle. C wins. B stays BUSY and retries on the next edge, so `B_done_ack` comes one cycle later.
- Push and pop on the same queue in the same cycle are legal. A pop sees only entries present before the edge.

## Timing

- All state is registered. Every output except `reset_len` comes from a register.
- Outputs while `rst` is 0: all ack and rdy outputs are 0, all sels are 0, `buf_owner` is 0, `sn_starve_cnt` is 0.
- Reset takes effect immediately and asynchronously, including in the middle of a handshake. Queues re-initialise; any in-flight agent is dropped.
- First edge after `rst` rises: A goes EMPTY → RDY, giving `rdy_for_A`=1 and `sn_sel`=0.
- Done input sampled 1 on edge k → done_ack is high for the cycle after edge k. The earliest next rdy is at edge k+1; at least one EMPTY cycle separates consecutive buffers on an agent.
- A buffer's latency from `A_done` to `rdy_for_B` is 2 edges when FILT was empty and B is EMPTY.

## Configuration

- `PNQ_STARVE_CNT_EN` defined:
  - `sn_starve_cnt` increments on every edge where A is EMPTY and FREE is empty;
  - it saturates at all-ones;
  - it clears only on reset.
- `PNQ_STARVE_CNT_EN` undefined:
  - `sn_starve_cnt` is constant 0;
  - no counter logic is built.

## Test plan

- Reset release with `NUM_BUFS`=4 → next cycle `rdy_for_A`=1, `sn_sel`=0, `buf_owner`=8'b00000001; `rdy_for_B`=0 and `rdy_for_C`=0.
- Accept path:
  - ack and `A_done` on buffer 0 → `A_done_ack` for 1 cycle, then `rdy_for_B`=1 with `cpu_sel`=0;
  - `B_acc` → `rdy_for_C`=1 with `fwd_sel`=0;
  - `C_done` → snooper later receives buffers in order 1, 2, 3, 0.
- Reject: `B_rej` on buffer 0 → `B_done_ack` pulses, `rdy_for_C` stays 0, buffer 0 appears after 1, 2, 3 in `sn_sel` order.
- Conflict: `B_rej` (buffer 1) and `C_done` (buffer 0) high on the same edge → `C_done_ack` that cycle, `B_done_ack` the following cycle; FREE order 0 then 1.
- Starvation, with the CPU never acking and the snooper completing 4 buffers → `rdy_for_A` stays 0.
  - Macro defined: `sn_starve_cnt` rises by 1 per cycle.
  - Macro undefined: `sn_starve_cnt` stays 0.
- Asserting `rst`=0 mid-BUSY on every agent → all outputs 0 without a clock edge; after release, `sn_sel` restarts at 0.
